// File: rtl/cube_cpu_ctrl_pkg.sv
// Shared definitions for the cube CPU: instruction fields, opcodes and
// controller states. The ALU decodes the same opcode values.
package cube_cpu_ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 8;
    localparam int DATA_W  = 8;

    localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OP_W-1:0] OP_INC    = 4'h1;
    localparam logic [OP_W-1:0] OP_DEC    = 4'h2;
    localparam logic [OP_W-1:0] OP_CHECK  = 4'h3;
    localparam logic [OP_W-1:0] OP_LOAD   = 4'h4;
    localparam logic [OP_W-1:0] OP_STORE  = 4'h5;
    localparam logic [OP_W-1:0] OP_LI     = 4'h6;
    localparam logic [OP_W-1:0] OP_MOV    = 4'h7;
    localparam logic [OP_W-1:0] OP_RL_90  = 4'h8;
    localparam logic [OP_W-1:0] OP_UD_90  = 4'h9;
    localparam logic [OP_W-1:0] OP_FB_90  = 4'hA;
    localparam logic [OP_W-1:0] OP_RL_270 = 4'hB;
    localparam logic [OP_W-1:0] OP_UD_270 = 4'hC;
    localparam logic [OP_W-1:0] OP_FB_270 = 4'hD;
    localparam logic [OP_W-1:0] OP_JZ     = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT   = 4'hF;

    // A zero instruction word decodes as NOP, so it is the safe IR reset value.
    localparam logic [INSTR_W-1:0] INSTR_NOP  = 16'h0000;
    localparam logic [INSTR_W-1:0] INSTR_HALT = 16'hF000;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    // Rotations occupy the contiguous opcode range 8..D.
    function automatic logic is_rotation(input logic [OP_W-1:0] op);
        return (op >= OP_RL_90) && (op <= OP_FB_270);
    endfunction

    // Ops whose EXEC-cycle ALU result is written back to R[rd].
    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_LI) ||
               (op == OP_MOV) || is_rotation(op);
    endfunction

endpackage

// File: rtl/cube_cpu_ctrl_regfile.sv
// Register file for the cube CPU: NREG x DATA_W storage, two asynchronous
// read ports, one synchronous write port, asynchronous clear and an R[6] tap.
module cube_regfile
    import cube_cpu_ctrl_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [REG_W-1:0]  raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] reg6
);

    logic [DATA_W-1:0] regs [NREG];

    assign rdata0 = regs[raddr0];
    assign rdata1 = regs[raddr1];
    assign reg6   = regs[6];

    // Clear every register on reset; otherwise write one register per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cube_cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the cube CPU. Drives the
// external combinational ALU and routes every result, LOAD data included,
// through it before writeback. Owns the PC, IR, zero flag and memory ports.
module cube_cpu_ctrl
    import cube_cpu_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8,
    parameter int NREG    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_in0,
    output logic [DATA_W-1:0]  alu_in1,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_zf,
    output logic               halted,
    output logic [DATA_W-1:0]  reg6
);

    state_t             state;
    logic [IMEM_AW-1:0] pc;
    logic [INSTR_W-1:0] ir;
    logic               zf;

    logic [OP_W-1:0]    ir_op;
    logic [REG_W-1:0]   ir_rd;
    logic [REG_W-1:0]   ir_rs;
    logic [IMM_W-1:0]   ir_imm;
    logic [DATA_W-1:0]  rd_val;
    logic [DATA_W-1:0]  rs_val;
    logic               rf_we;
    logic               rot_invalid;
    logic [IMEM_AW-1:0] pc_inc;

    assign ir_op  = ir[15:12];
    assign ir_rd  = ir[11:9];
    assign ir_rs  = ir[8:6];
    assign ir_imm = ir[7:0];

    assign imem_addr = pc;
    assign pc_inc    = pc + IMEM_AW'(1);

    // Orientations 110 and 111 do not exist, so a rotation of such a value
    // leaves the register untouched.
    assign rot_invalid = is_rotation(ir_op) && (rd_val[2:0] >= 3'd6);

    assign rf_we = ((state == ST_EXEC) && writes_rd(ir_op) && !rot_invalid) ||
                   (state == ST_MEM);

    cube_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr0 (ir_rd),
        .rdata0 (rd_val),
        .raddr1 (ir_rs),
        .rdata1 (rs_val),
        .we     (rf_we),
        .waddr  (ir_rd),
        .wdata  (alu_out),
        .reg6   (reg6)
    );

    // ALU and data-memory drive; everything idles at zero outside EXEC/MEM.
    always_comb begin
        alu_op     = OP_NOP;
        alu_in0    = '0;
        alu_in1    = '0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;
        if (state == ST_EXEC) begin
            case (ir_op)
                OP_INC, OP_DEC, OP_RL_90, OP_UD_90, OP_FB_90,
                OP_RL_270, OP_UD_270, OP_FB_270: begin
                    alu_op  = ir_op;
                    alu_in0 = rd_val;
                end
                OP_MOV: begin
                    alu_op  = ir_op;
                    alu_in0 = rs_val;
                end
                OP_LI: begin
                    alu_op  = ir_op;
                    alu_in0 = ir_imm;
                end
                OP_CHECK: begin
                    alu_op  = ir_op;
                    alu_in0 = rd_val;
                    alu_in1 = rs_val;
                end
                OP_STORE: begin
                    alu_op     = ir_op;
                    alu_in0    = rd_val;
                    dmem_addr  = DMEM_AW'(ir_imm);
                    dmem_wdata = alu_out;
                    dmem_we    = 1'b1;
                end
                OP_LOAD: begin
                    dmem_addr = DMEM_AW'(ir_imm);
                end
                default: begin
                    alu_op = OP_NOP;
                end
            endcase
        end else if (state == ST_MEM) begin
            alu_op    = OP_LOAD;
            alu_in0   = dmem_rdata;
            dmem_addr = DMEM_AW'(ir_imm);
        end
    end

    // Instruction sequencing, PC, IR, zero flag and the halted indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_FETCH;
            pc     <= '0;
            ir     <= INSTR_NOP;
            zf     <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir    <= imem_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (ir_op)
                        OP_HALT: begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                        OP_LOAD: begin
                            state <= ST_MEM;
                        end
                        OP_CHECK: begin
                            zf    <= alu_zf;
                            pc    <= pc_inc;
                            state <= ST_FETCH;
                        end
                        OP_JZ: begin
                            pc    <= zf ? IMEM_AW'(ir_imm) : pc_inc;
                            state <= ST_FETCH;
                        end
                        default: begin
                            pc    <= pc_inc;
                            state <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    pc    <= pc_inc;
                    state <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/cube_cpu_ctrl.md
Name: cube_cpu_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller and register file for the cube CPU.
- Sits directly around the 8-bit combinational ALU: it feeds the ALU's op, in0 and in1, and consumes out and zf.
- Every data result, including LOAD data, passes through the ALU before it is written back to R[rd].
- Owns the PC, the 8x8 register file, the zero flag and the instruction/data memory ports.

Parameters:
- IMEM_AW, 8, instruction address width; the PC wraps at 2^IMEM_AW.
- DMEM_AW, 8, data address width; must be ≤ 8, taken from imm8.
- NREG, 8, register count; fixed by the 3-bit rd/rs fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  IMEM_AW  instruction address (= PC).
- imem_data  in  16  instruction word; synchronous ROM, valid the cycle after the address.
- dmem_addr  out  DMEM_AW  data address.
- dmem_wdata  out  8  store data.
- dmem_we  out  1  write strobe, one cycle wide.
- dmem_rdata  in  8  load data; synchronous read, valid the cycle after the address.
- alu_op  out  4  ALU operation code.
- alu_in0  out  8  ALU operand 0.
- alu_in1  out  8  ALU operand 1.
- alu_out  in  8  ALU result.
- alu_zf  in  1  ALU compare result.
- halted  out  1  high while in the HALT state.
- reg6  out  8  live copy of R[6], for the board display.

Behaviour:
- Instruction format: op[15:12], rd[11:9], rs[8:6], imm8[7:0]. rs and imm8 overlap; each op uses only one of them.
- Opcodes: NOP=0, INC=1, DEC=2, CHECK=3, LOAD=4, STORE=5, LI=6, MOV=7, RL_90=8, UD_90=9, FB_90=A, RL_270=B, UD_270=C, FB_270=D, JZ=E, HALT=F.
- States: FETCH -> DECODE -> EXEC -> FETCH. LOAD inserts MEM after EXEC. HALT is terminal.
- FETCH: imem_addr = PC.
- DECODE: IR <= imem_data.
- EXEC: drive the ALU combinationally, sample alu_out/alu_zf at the clock edge, update PC.
- Latency: 3 cycles per instruction; LOAD takes 4.
- ALU drive (combinational from state and IR). Outside EXEC/MEM: alu_op=NOP, alu_in0=0, alu_in1=0.
  - INC, DEC and rotations: in0=R[rd]; write R[rd]<=alu_out.
  - MOV: in0=R[rs]; write R[rd].
  - LI: in0=imm8; write R[rd].
  - CHECK: in0=R[rd], in1=R[rs]; zf<=alu_zf; no register write.
  - STORE: in0=R[rd], dmem_addr=imm8, dmem_wdata=alu_out, dmem_we=1 in EXEC only.
  - LOAD: EXEC drives dmem_addr=imm8 with alu_op=NOP. MEM drives alu_op=LOAD, in0=dmem_rdata, and writes R[rd]<=alu_out at the end of MEM.
- zf is updated only by CHECK. All other ops, including JZ, preserve it.
- Rotations with R[rd][2:0] ∈ {110,111} (invalid orientation): the writeback is suppressed and R[rd] is unchanged.
- PC update:
  - Default: PC <= PC+1 at the end of EXEC (end of MEM for LOAD), modulo 2^IMEM_AW, so 255 -> 0.
  - JZ: PC <= imm8 if zf=1, else PC+1.
  - HALT: the PC is not incremented; the state goes to HALT with halted=1. Only reset leaves HALT.
- NOP: PC+1 only.
- Reset (asynchronous, any state, including mid-LOAD or mid-STORE):
  - Registers: PC=0, IR=0, R[0..7]=0, zf=0, state=FETCH.
  - Outputs: imem_addr=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, alu_op=0, alu_in0=0, alu_in1=0, halted=0, reg6=0.
  - An interrupted store is not issued.

Decomposition:
- The opcode localparams and the state encoding belong in the shared def.h. The ALU consumes the same opcode values.
- Instruction field widths and the NOP/HALT constants also go in def.h.
- One sub-module is natural: cube_regfile, with 8x8 storage, two asynchronous read ports, one synchronous write port, asynchronous clear, and the reg6 tap.
- The FSM and PC stay in the top module.

Test Plan:
- Reset, then program LI r6,0x2A; HALT -> reg6=0x2A by cycle 6; halted=1; PC stays 1; further clocks change nothing.
- LI r1,0x05; INC r1; DEC r1; DEC r1 -> R1=0x04; zf stays 0 throughout.
- LI r2,0x10; STORE r2,@0x80; LOAD r3,@0x80 -> dmem_we high for exactly 1 cycle with addr 0x80 and data 0x10; R3=0x10; the LOAD takes 4 cycles.
- LI r1,7; LI r2,7; CHECK r1,r2; JZ 0x40 -> PC=0x40. Repeat with r2=8 -> PC=4.
- LI r4,0x00; RL_90 r4 -> R4=0x02. Then LI r4,0x06; RL_90 r4 -> R4=0x06 (writeback suppressed).
- Place an instruction at 0xFF and no jump -> the next fetch address is 0x00. Assert rst_n low during the MEM state of a LOAD -> all outputs 0 immediately; no register write.
